// File: rtl/cacheline_burst_adaptor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_burst_adaptor_pkg
// Purpose  : Shared types and sizing for the cache-line to memory-burst
//            adaptor: line/beat word types and the adaptor state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cacheline_burst_adaptor_pkg;

  localparam int unsigned S_LINE   = 256;               // cache line width
  localparam int unsigned S_BURST  = 64;                // memory bus width
  localparam int unsigned S_BEATS  = S_LINE / S_BURST;  // beats per line
  localparam int unsigned S_OFFSET = 5;                 // line offset bits

  typedef logic [S_LINE-1:0]  llc_cacheline;
  typedef logic [S_BURST-1:0] burst_word;

  typedef enum logic [1:0] {
    ADAPTOR_IDLE     = 2'd0,
    ADAPTOR_RD_BURST = 2'd1,
    ADAPTOR_WR_BURST = 2'd2,
    ADAPTOR_DONE     = 2'd3
  } adaptor_state_t;

endpackage : cacheline_burst_adaptor_pkg
`default_nettype wire

// File: rtl/cacheline_burst_adaptor_line_beat_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_beat_buffer
// Purpose  : One cache line of storage split into beat-sized slots. Serves
//            both directions: read bursts fill it beat by beat, write bursts
//            load it whole and drain it beat by beat.
// Ports    : clk/rst      - clock, asynchronous active-high reset
//            load_i       - parallel load of line_i (takes priority)
//            line_i       - full line to load
//            cap_i        - capture beat_i into slot beat_idx_i
//            beat_idx_i   - slot index for both capture and read-out
//            beat_i       - beat data to capture
//            line_o       - full buffer contents
//            beat_o       - slot selected by beat_idx_i
// Revision : 1.0 - initial release
// ============================================================================
module line_beat_buffer #(
  parameter int unsigned S_LINE  = 256,
  parameter int unsigned S_BURST = 64,
  parameter int unsigned S_BEATS = S_LINE / S_BURST,
  parameter int unsigned IDX_W   = $clog2(S_BEATS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [S_LINE-1:0]  line_i,
  input  logic               cap_i,
  input  logic [IDX_W-1:0]   beat_idx_i,
  input  logic [S_BURST-1:0] beat_i,
  output logic [S_LINE-1:0]  line_o,
  output logic [S_BURST-1:0] beat_o
);

  logic [S_BURST-1:0] slot_q [S_BEATS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(S_BEATS); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(S_BEATS); i++) begin
        if (load_i) begin
          slot_q[i] <= line_i[i*S_BURST +: S_BURST];
        end else if (cap_i && (beat_idx_i == IDX_W'(i))) begin
          slot_q[i] <= beat_i;
        end
      end
    end
  end

  // Beat 0 occupies the least-significant bits of the line.
  for (genvar g = 0; g < int'(S_BEATS); g++) begin : g_pack
    assign line_o[g*S_BURST +: S_BURST] = slot_q[g];
  end

  // Read port comes straight from registers, never from line_i.
  assign beat_o = slot_q[beat_idx_i];

endmodule : line_beat_buffer
`default_nettype wire

// File: rtl/cacheline_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_burst_adaptor
// Purpose  : Presents a single-transaction cache-line interface to the cache
//            and converts each line read/write into an S_BEATS-beat burst on
//            the physical memory bus.
// Ports    : clk/rst    - clock, asynchronous active-high reset
//            line_i     - write line from cache
//            line_o     - last completed read line to cache
//            address_i  - line address from cache
//            read_i     - cache line-read request
//            write_i    - cache line-write request (wins over read_i)
//            resp_o     - one-cycle completion pulse to cache
//            burst_i    - read beat from memory
//            burst_o    - write beat to memory
//            address_o  - line-aligned burst base address to memory
//            read_o     - memory read request
//            write_o    - memory write request
//            resp_i     - memory beat strobe
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_burst_adaptor
  import cacheline_burst_adaptor_pkg::*;
#(
  parameter int unsigned S_LINE   = cacheline_burst_adaptor_pkg::S_LINE,
  parameter int unsigned S_BURST  = cacheline_burst_adaptor_pkg::S_BURST,
  parameter int unsigned S_BEATS  = S_LINE / S_BURST,
  parameter int unsigned S_OFFSET = cacheline_burst_adaptor_pkg::S_OFFSET
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_LINE-1:0]  line_i,
  output logic [S_LINE-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [S_BURST-1:0] burst_i,
  output logic [S_BURST-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned     CNT_W     = $clog2(S_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(S_BEATS - 1);
  localparam logic [31:0]     ADDR_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

  adaptor_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [S_LINE-1:0] line_q, line_d;

  logic              buf_load;
  logic              buf_cap;
  logic [S_LINE-1:0] buf_line;
  logic [S_BURST-1:0] buf_beat;

  line_beat_buffer #(
    .S_LINE  (S_LINE),
    .S_BURST (S_BURST),
    .S_BEATS (S_BEATS),
    .IDX_W   (CNT_W)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (buf_load),
    .line_i     (line_i),
    .cap_i      (buf_cap),
    .beat_idx_i (cnt_q),
    .beat_i     (burst_i),
    .line_o     (buf_line),
    .beat_o     (buf_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ADAPTOR_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    line_d   = line_q;
    buf_load = 1'b0;
    buf_cap  = 1'b0;

    case (state_q)
      ADAPTOR_IDLE: begin
        if (write_i) begin
          buf_load = 1'b1;
          addr_d   = address_i & ADDR_MASK;
          state_d  = ADAPTOR_WR_BURST;
        end else if (read_i) begin
          addr_d   = address_i & ADDR_MASK;
          state_d  = ADAPTOR_RD_BURST;
        end
      end

      ADAPTOR_RD_BURST: begin
        if (resp_i) begin
          buf_cap = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            // The last beat is the top slot; merge it directly so the
            // committed line is complete on the same edge.
            line_d  = {burst_i, buf_line[S_LINE-S_BURST-1:0]};
            state_d = ADAPTOR_DONE;
          end
        end
      end

      ADAPTOR_WR_BURST: begin
        if (resp_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = ADAPTOR_DONE;
          end
        end
      end

      ADAPTOR_DONE: begin
        state_d = ADAPTOR_IDLE;
      end

      default: begin
        state_d = ADAPTOR_IDLE;
      end
    endcase
  end

  // Strobes decode directly from the state register so an asynchronous
  // reset drops them in the same time step.
  assign read_o    = (state_q == ADAPTOR_RD_BURST);
  assign write_o   = (state_q == ADAPTOR_WR_BURST);
  assign resp_o    = (state_q == ADAPTOR_DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;
  assign burst_o   = buf_beat;

endmodule : cacheline_burst_adaptor
`default_nettype wire
